// File: rtl/mdu_pkg.sv
// Shared execute-stage types: ALU and MDU function encodings plus MDU helpers.
// MDU encodings put the word-op flag in bit 3 over the matching base op in bits 2:0.
package pipes;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR   = 4'd8, ALU_AND = 4'd9
  } alufunc_t;

  typedef enum logic [3:0] {
    MDU_MUL   = 4'h0, MDU_MULH  = 4'h1, MDU_MULHSU = 4'h2, MDU_MULHU = 4'h3,
    MDU_DIV   = 4'h4, MDU_DIVU  = 4'h5, MDU_REM    = 4'h6, MDU_REMU  = 4'h7,
    MDU_MULW  = 4'h8, MDU_DIVW  = 4'hC, MDU_DIVUW  = 4'hD, MDU_REMW  = 4'hE,
    MDU_REMUW = 4'hF
  } mdufunc_t;

  localparam int MDU_W_ITERS = 32;

  typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_DONE} mdu_state_t;

  // MUL is treated as signed; its low half is identical either way.
  function automatic logic mdu_a_signed(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  endfunction

  function automatic logic mdu_b_signed(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Single-step radix-2 iterator: shift-add multiplier or restoring divider.
// Outputs are the post-step values so the top can register the final result directly.
module mdu_core #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi_nxt,
  output logic [WIDTH-1:0] o_lo_nxt
);
  logic [WIDTH-1:0] r_hi, r_lo, r_d;
  logic             r_div;
  logic [WIDTH:0]   w_sum, w_sh, w_diff;

  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
    w_sh   = {r_hi, r_lo[WIDTH-1]};
    // Remainder < divisor keeps w_sh < 2*divisor, so bit WIDTH of the difference is the borrow.
    w_diff = w_sh - {1'b0, r_d};
    if (r_div) begin
      o_hi_nxt = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      o_lo_nxt = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      o_hi_nxt = w_sum[WIDTH:1];
      o_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_d   <= '0;
      r_div <= 1'b0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_d   <= i_b;
      r_div <= i_div;
    end else if (i_step) begin
      r_hi  <= o_hi_nxt;
      r_lo  <= o_lo_nxt;
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV64M multiply/divide unit: FSM, sign handling, divide shortcuts, result register.
// Define MDU_WORD_OP_EN to decode the 32-bit W ops; otherwise they alias their full-width ops.
module mdu
  import pipes::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  mdufunc_t         func,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c
);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_iters;
  logic [2:0]         r_op, w_op;
  logic               r_neg_a, r_neg_b;
  logic [WIDTH-1:0]   r_c;

  logic               w_accept, w_sa, w_sb, w_neg_a, w_neg_b, w_is_div, w_div0, w_ovf, w_short;
  logic               w_load, w_step, w_last;
  logic [WIDTH-1:0]   w_ea, w_eb, w_mag_a, w_mag_b, w_ld_a, w_short_raw, w_short_val;
  logic [WIDTH-1:0]   w_hi, w_lo, w_mulres, w_quo, w_rem, w_res, w_res_x;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;

  assign w_accept = in_valid & in_ready;
  assign w_op     = func[2:0];
  assign w_is_div = w_op[2];
  assign w_sa     = mdu_a_signed(w_op);
  assign w_sb     = mdu_b_signed(w_op);

`ifdef MDU_WORD_OP_EN
  logic w_word, r_word;

  function automatic logic [WIDTH-1:0] sext32(input logic [WIDTH-1:0] v);
    return {{(WIDTH-32){v[31]}}, v[31:0]};
  endfunction

  assign w_word  = func[3];
  assign w_ea    = !w_word ? a : (w_sa ? sext32(a) : {{(WIDTH-32){1'b0}}, a[31:0]});
  assign w_eb    = !w_word ? b : (w_sb ? sext32(b) : {{(WIDTH-32){1'b0}}, b[31:0]});
  assign w_iters = w_word ? CNT_W'(MDU_W_ITERS) : CNT_W'(WIDTH);
  assign w_ovf   = w_is_div & w_sa & w_sb &
                   (w_word ? (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF)
                           : (a == MOST_NEG) && (b == '1));
  // A 32-bit dividend must sit at the top so its bits shift out during the 32 steps.
  assign w_ld_a  = (w_word & w_is_div) ? (w_mag_a << (WIDTH-32)) : w_mag_a;
  assign w_prod  = r_word ? ({w_hi, w_lo} >> (WIDTH-32)) : {w_hi, w_lo};
  assign w_res_x = r_word ? sext32(w_res) : w_res;
  assign w_short_val = w_word ? sext32(w_short_raw) : w_short_raw;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 r_word <= 1'b0;
    else if (w_accept && !flush) r_word <= w_word;
  end
`else
  logic w_unused_func;

  assign w_unused_func = func[3];
  assign w_ea        = a;
  assign w_eb        = b;
  assign w_iters     = CNT_W'(WIDTH);
  assign w_ovf       = w_is_div & w_sa & w_sb & (a == MOST_NEG) & (b == '1);
  assign w_ld_a      = w_mag_a;
  assign w_prod      = {w_hi, w_lo};
  assign w_res_x     = w_res;
  assign w_short_val = w_short_raw;
`endif

  assign w_neg_a = w_sa & w_ea[WIDTH-1];
  assign w_neg_b = w_sb & w_eb[WIDTH-1];
  assign w_mag_a = w_neg_a ? -w_ea : w_ea;
  assign w_mag_b = w_neg_b ? -w_eb : w_eb;
  assign w_div0  = w_is_div & (w_eb == '0);
  assign w_short = w_div0 | w_ovf;
  assign w_short_raw = w_op[1] ? (w_div0 ? w_ea : '0) : (w_div0 ? '1 : w_ea);

  assign w_load = w_accept & ~flush;
  assign w_step = (r_state == MDU_RUN) & ~flush;
  assign w_last = (r_state == MDU_RUN) && (r_cnt == CNT_W'(1));

  mdu_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_div    (w_is_div),
    .i_a      (w_ld_a),
    .i_b      (w_mag_b),
    .o_hi_nxt (w_hi),
    .o_lo_nxt (w_lo)
  );

  // Post-correction runs on the core's final-step values, landing in r_c on the last RUN edge.
  assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_mulres = (r_op == 3'd0) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
  assign w_quo    = (r_neg_a ^ r_neg_b) ? -w_lo : w_lo;
  assign w_rem    = r_neg_a ? -w_hi : w_hi;
  assign w_res    = r_op[2] ? (r_op[1] ? w_rem : w_quo) : w_mulres;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      MDU_IDLE: if (in_valid) w_state_nxt = w_short ? MDU_DONE : MDU_RUN;
      MDU_RUN:  if (r_cnt == CNT_W'(1)) w_state_nxt = MDU_DONE;
      MDU_DONE: if (out_ready) w_state_nxt = MDU_IDLE;
      default:  w_state_nxt = MDU_IDLE;
    endcase
    if (flush) w_state_nxt = MDU_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_c     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= w_iters;
        r_op    <= w_op;
        r_neg_a <= w_neg_a;
        r_neg_b <= w_neg_b;
        if (w_short) r_c <= w_short_val;
      end else if (r_state == MDU_RUN) begin
        r_cnt <= r_cnt - 1'b1;
        if (w_last) r_c <= w_res_x;
      end
    end
  end

  assign in_ready  = (r_state == MDU_IDLE);
  assign out_valid = (r_state == MDU_DONE);
  assign c         = r_c;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu (WIDTH=64), expectations hand-computed.
module tb_mdu;
  import pipes::*;

  logic        clk, resetn, in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0] a, b, c;
  mdufunc_t    func;

  int n_chk  = 0;
  int n_pass = 0;

  mdu #(.WIDTH(64)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .func      (func),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Offer one op, wait (bounded) for out_valid, capture c, then consume it.
  task automatic run_op(input mdufunc_t f, input logic [63:0] ia, input logic [63:0] ib,
                        output int lat, output logic [63:0] res);
    in_valid = 1'b1; func = f; a = ia; b = ib;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = c;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [63:0] res;
    logic        seen;
    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; func = MDU_MUL;
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_c", c, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(MDU_MUL, 64'd7, -64'sd3, lat, res);
    chk("mul_c", res, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mul_lat", 64'(lat), 64'd65);

    run_op(MDU_MULHU, '1, '1, lat, res);
    chk("mulhu_c", res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mulhu_lat", 64'(lat), 64'd65);

    run_op(MDU_MULH, '1, '1, lat, res);
    chk("mulh_c", res, 64'd0);

    run_op(MDU_MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, lat, res);
    chk("mulhsu_c", res, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op(MDU_DIV, -64'sd7, 64'd2, lat, res);
    chk("div_c", res, 64'hFFFF_FFFF_FFFF_FFFD);

    run_op(MDU_REM, -64'sd7, 64'd2, lat, res);
    chk("rem_c", res, 64'hFFFF_FFFF_FFFF_FFFF);

    run_op(MDU_DIVU, 64'd7, 64'd0, lat, res);
    chk("divu0_c", res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divu0_lat", 64'(lat), 64'd1);

    run_op(MDU_REM, 64'd5, 64'd0, lat, res);
    chk("rem0_c", res, 64'd5);
    chk("rem0_lat", 64'(lat), 64'd1);

    run_op(MDU_DIV, 64'h8000_0000_0000_0000, '1, lat, res);
    chk("ovf_div_c", res, 64'h8000_0000_0000_0000);
    chk("ovf_div_lat", 64'(lat), 64'd1);

    run_op(MDU_REM, 64'h8000_0000_0000_0000, '1, lat, res);
    chk("ovf_rem_c", res, 64'd0);
    chk("ovf_rem_lat", 64'(lat), 64'd1);

    run_op(MDU_REMU, 64'd100, 64'd7, lat, res);
    chk("remu_c", res, 64'd2);

    run_op(MDU_DIVW, 64'h0000_0000_8000_0000, 64'd1, lat, res);
`ifdef MDU_WORD_OP_EN
    chk("divw_c", res, 64'hFFFF_FFFF_8000_0000);
    chk("divw_lat", 64'(lat), 64'd33);
`else
    chk("divw_c", res, 64'h0000_0000_8000_0000);
    chk("divw_lat", 64'(lat), 64'd65);
`endif

    // Result must hold while the consumer stalls.
    in_valid = 1'b1; func = MDU_DIVU; a = 64'd100; b = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_vld", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_c", c, 64'd14);
    end
    chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold_release", {63'd0, in_ready}, 64'd1);

    // Flush at RUN cycle 20.
    in_valid = 1'b1; func = MDU_DIV; a = 64'd1000; b = 64'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", {63'd0, in_ready}, 64'd1);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", {63'd0, seen}, 64'd0);

    run_op(MDU_DIV, 64'd1000, -64'sd10, lat, res);
    chk("post_flush_c", res, -64'sd100);
    chk("post_flush_lat", 64'(lat), 64'd65);

    // Asynchronous reset mid-RUN.
    in_valid = 1'b1; func = MDU_MUL; a = 64'd3; b = 64'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_c", c, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_op(MDU_MUL, 64'd3, 64'd5, lat, res);
    chk("post_rst_c", res, 64'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative, parametrised multiply/divide unit for the execute stage, the multi-cycle companion to the single-cycle ALU. It accepts one RV64M operation via a valid/ready handshake and computes it with a radix-2 shift-add multiplier or restoring divider, one bit per cycle. It holds the result until the writeback-side consumer takes it. The execute stage stalls on `in_ready`/`out_valid`.

## Interface
- `WIDTH`, 64: operand/result width in bits (even, ≥ 8).
- `CNT_W`, $clog2(WIDTH+1): iteration counter width.
- `clk`  in  1: clock, rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operation offered.
- `in_ready`  out  1: unit can accept; high only in IDLE.
- `a`, `b`  in  WIDTH: rs1, rs2 operands.
- `func`  in  mdufunc_t: operation select.
- `flush`  in  1: abandon the current operation. No output is produced.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result.
- `c`  out  WIDTH: result; stable while `out_valid` is high and `out_ready` is low.

## Operation
- Ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. With `MDU_WORD_OP_EN` also MULW, DIVW, DIVUW, REMW, REMUW.
- Accept on the edge where `in_valid & in_ready`. Latch |a|, |b|, the sign flags, and `func`. Operands are treated as signed per op (MULHSU: a signed, b unsigned).
- States:
  - IDLE: on accept go to RUN with counter = N, where N = WIDTH, or 32 for W ops.
  - RUN: one iteration per cycle, counter decrements. At counter = 1, go to DONE.
  - DONE: `out_valid`=1. On `out_ready` go to IDLE.
- Multiply: unsigned 2·WIDTH-bit product of the magnitudes, negated if the signs differ. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- Divide: unsigned restoring division of the magnitudes. Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- Divide shortcuts (IDLE→DONE directly, no RUN):
  - Divisor 0: quotient all-ones, remainder = a.
  - Signed overflow (a = most-negative, b = −1): quotient = a, remainder = 0.
- W ops: the low 32 bits of a/b are used, sign- or zero-extended per op. The 32-bit result is sign-extended to WIDTH.
- `flush` high in any state forces IDLE at the next edge and drops `out_valid`. `flush` takes priority over accept and completion in the same cycle.

## Timing
- Reset: state IDLE, `in_ready`=1, `out_valid`=0, `c`=0, counter 0, all datapath registers 0.
- Normal op: `out_valid` rises N+1 cycles after the accepting edge (65 for WIDTH=64, 33 for W ops).
- Shortcut op: `out_valid` rises 1 cycle after the accepting edge.
- The unit never accepts while busy. Back-to-back throughput is one op per N+2 cycles when `out_ready` is held high (the DONE cycle plus the IDLE/accept cycle).
- `c` is registered; there is no combinational path from any input to any output.
- `resetn` deasserted mid-operation (reset asserted during RUN or DONE) clears everything immediately. The in-flight op is lost.

## Configuration
- `MDU_WORD_OP_EN` defined: the W ops are decoded, run for 32 iterations, and results are sign-extended.
- `MDU_WORD_OP_EN` undefined: the W encodings are treated as their WIDTH-bit counterparts (MULW→MUL, DIVW→DIV, and so on), all ops take WIDTH iterations, and the 32-bit extension logic is absent.

## Structure
- `mdufunc_t` enum and the constant `MDU_W_ITERS` = 32 go in the shared `pipes` package, alongside `alufunc_t`.
- One sub-module, `mdu_core`: a single-step iterator that serves as both shift-add multiplier and restoring divider, holding the accumulator/remainder and the multiplier/quotient shift registers.
- The top level holds the FSM, counter, sign pre-processing and post-correction, shortcut detection, and the output register.

## Test plan
- MUL a=7, b=−3 (WIDTH=64) → `c`=0xFFFF_FFFF_FFFF_FFEB. `out_valid` rises exactly 65 cycles after accept.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → `c`=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0.
- DIV a=−7, b=2 → −3. REM with the same operands → −1. DIVU a=7, b=0 → all-ones after 1 cycle. REM a=5, b=0 → 5.
- DIV a=0x8000_0000_0000_0000, b=−1 → `c`=a. REM with the same operands → 0. Both take 1 cycle.
- DIVW a=0x0000_0000_8000_0000, b=1 → 0xFFFF_FFFF_8000_0000 after 33 cycles (macro on). With the macro off it behaves as DIV, giving 0x8000_0000 after 65 cycles.
- Two cases:
  - Hold `out_ready`=0 for 10 cycles in DONE: `c` stays stable and `in_ready` stays 0.
  - Assert `flush` at RUN cycle 20: IDLE at the next edge, `out_valid` never rises, and the next op computes correctly.
